// File: rtl/sram_port_sched.sv
// rtl/sram_port_sched.sv - two-client round-robin scheduler for one SRAM macro port with NAP control
module sram_port_sched #(
    parameter int          AW          = 13,
    parameter int          DW          = 32,
    parameter int          RD_LAT      = 1,
    parameter int          IDLE_CYCLES = 16,
    parameter int          WAKE_CYCLES = 2,
    parameter logic [3:0]  DVS_VAL     = 4'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_gnt,
    output logic          c0_rvalid,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_gnt,
    output logic          c1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          sram_csn,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout,
    output logic          sram_nap,
    output logic          sram_dvse,
    output logic [3:0]    sram_dvs,
    output logic          busy
);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_SLEEP  = 2'd1;
    localparam logic [1:0] ST_WAKE   = 2'd2;

    // Counter widths; at least one bit so a zero IDLE_CYCLES still builds.
    localparam int IW = (IDLE_CYCLES < 2) ? 1 : $clog2(IDLE_CYCLES + 1);
    localparam int WW = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
    localparam logic [WW-1:0] WAKE_END = WW'(WAKE_CYCLES - 1);

    logic [1:0]      r_state;
    logic            r_rr_ptr;
    logic [IW-1:0]   r_idle_cnt;
    logic [WW-1:0]   r_wake_cnt;
    logic            r_nap;
    logic            r_csn;
    logic            r_wen;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_din;
    logic [RD_LAT:0] r_pipe_vld;
    logic [RD_LAT:0] r_pipe_id;
    logic [DW-1:0]   r_rdata;
    logic            r_c0_rvalid;
    logic            r_c1_rvalid;

    logic            w_active;
    logic            w_acc;
    logic            w_acc_id;
    logic            w_acc_we;
    logic [AW-1:0]   w_acc_addr;
    logic [DW-1:0]   w_acc_wdata;
    logic            w_push_rd;
    logic            w_pipe_empty;

    assign w_active     = (r_state == ST_ACTIVE);
    assign c0_gnt       = w_active & c0_req & (~c1_req | ~r_rr_ptr);
    assign c1_gnt       = w_active & c1_req & (~c0_req |  r_rr_ptr);
    assign w_acc        = c0_gnt | c1_gnt;
    assign w_acc_id     = c1_gnt;
    assign w_acc_we     = w_acc_id ? c1_we    : c0_we;
    assign w_acc_addr   = w_acc_id ? c1_addr  : c0_addr;
    assign w_acc_wdata  = w_acc_id ? c1_wdata : c0_wdata;
    assign w_push_rd    = w_acc & ~w_acc_we;
    assign w_pipe_empty = ~|r_pipe_vld;

    assign sram_csn  = r_csn;
    assign sram_wen  = r_wen;
    assign sram_addr = r_addr;
    assign sram_din  = r_din;
    assign sram_nap  = r_nap;
    assign sram_dvse = 1'b0;
    assign sram_dvs  = DVS_VAL;
    assign rdata     = r_rdata;
    assign c0_rvalid = r_c0_rvalid;
    assign c1_rvalid = r_c1_rvalid;
    assign busy      = ~w_pipe_empty | ~w_active;

    // Register the accepted command onto the macro pins; idle cycles deselect the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csn  <= 1'b1;
            r_wen  <= 1'b1;
            r_addr <= '0;
            r_din  <= '0;
        end else if (w_acc) begin
            r_csn  <= 1'b0;
            r_wen  <= ~w_acc_we;
            r_addr <= w_acc_addr;
            r_din  <= w_acc_wdata;
        end else begin
            r_csn  <= 1'b1;
            r_wen  <= 1'b1;
        end
    end

    // Track read tags through the macro latency and return data to the issuing client.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            r_pipe_id   <= '0;
            r_rdata     <= '0;
            r_c0_rvalid <= 1'b0;
            r_c1_rvalid <= 1'b0;
        end else begin
            r_pipe_vld  <= {r_pipe_vld[RD_LAT-1:0], w_push_rd};
            r_pipe_id   <= {r_pipe_id[RD_LAT-1:0],  w_acc_id};
            r_c0_rvalid <= r_pipe_vld[RD_LAT] & ~r_pipe_id[RD_LAT];
            r_c1_rvalid <= r_pipe_vld[RD_LAT] &  r_pipe_id[RD_LAT];
            if (r_pipe_vld[RD_LAT]) begin
                r_rdata <= sram_dout;
            end
        end
    end

    // Round-robin pointer flips to the other client after every acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_acc) begin
            r_rr_ptr <= ~w_acc_id;
        end
    end

    // Power state machine: idle timeout into NAP, request-triggered wake sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACTIVE;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_nap      <= 1'b0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (w_acc) begin
                        r_idle_cnt <= '0;
                    end else begin
                        if (r_idle_cnt != IDLE_MAX) begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                        // Never nap with a read still owed to a client.
                        if ((IDLE_CYCLES != 0) && (r_idle_cnt == IDLE_MAX) && w_pipe_empty) begin
                            r_state <= ST_SLEEP;
                            r_nap   <= 1'b1;
                        end
                    end
                end
                ST_SLEEP: begin
                    r_idle_cnt <= '0;
                    if (c0_req | c1_req) begin
                        r_state    <= ST_WAKE;
                        r_nap      <= 1'b0;
                        r_wake_cnt <= '0;
                    end
                end
                ST_WAKE: begin
                    r_idle_cnt <= '0;
                    if (r_wake_cnt == WAKE_END) begin
                        r_state <= ST_ACTIVE;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_ACTIVE;
                    r_nap   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_sched.sv
// tb/tb_sram_port_sched.sv - directed self-checking bench for sram_port_sched
module tb_sram_port_sched;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        c0_req, c0_we, c1_req, c1_we;
    logic [12:0] c0_addr, c1_addr;
    logic [31:0] c0_wdata, c1_wdata;
    logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [31:0] rdata;
    logic        sram_csn, sram_wen, sram_nap, sram_dvse, busy;
    logic [12:0] sram_addr;
    logic [31:0] sram_din, sram_dout;
    logic [3:0]  sram_dvs;

    logic        b_c0_req, b_c0_we, b_c1_req, b_c1_we;
    logic [12:0] b_c0_addr, b_c1_addr;
    logic [31:0] b_c0_wdata, b_c1_wdata;
    logic        b_c0_gnt, b_c1_gnt, b_c0_rvalid, b_c1_rvalid;
    logic [31:0] b_rdata;
    logic        b_sram_csn, b_sram_wen, b_sram_nap, b_sram_dvse, b_busy;
    logic [12:0] b_sram_addr;
    logic [31:0] b_sram_din, b_sram_dout;
    logic [3:0]  b_sram_dvs;
    logic [31:0] b_d0, b_d1;

    logic [31:0] mem [0:8191];

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    sram_port_sched #(.AW(13), .DW(32), .RD_LAT(1), .IDLE_CYCLES(8), .WAKE_CYCLES(2), .DVS_VAL(4'h5)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid),
        .rdata(rdata), .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .sram_nap(sram_nap),
        .sram_dvse(sram_dvse), .sram_dvs(sram_dvs), .busy(busy)
    );

    sram_port_sched #(.AW(13), .DW(32), .RD_LAT(3), .IDLE_CYCLES(1), .WAKE_CYCLES(1), .DVS_VAL(4'h0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .c0_req(b_c0_req), .c0_we(b_c0_we), .c0_addr(b_c0_addr), .c0_wdata(b_c0_wdata),
        .c0_gnt(b_c0_gnt), .c0_rvalid(b_c0_rvalid),
        .c1_req(b_c1_req), .c1_we(b_c1_we), .c1_addr(b_c1_addr), .c1_wdata(b_c1_wdata),
        .c1_gnt(b_c1_gnt), .c1_rvalid(b_c1_rvalid),
        .rdata(b_rdata), .sram_csn(b_sram_csn), .sram_wen(b_sram_wen), .sram_addr(b_sram_addr),
        .sram_din(b_sram_din), .sram_dout(b_sram_dout), .sram_nap(b_sram_nap),
        .sram_dvse(b_sram_dvse), .sram_dvs(b_sram_dvs), .busy(b_busy)
    );

    // Macro model, latency 1: command sampled at the edge after it is registered.
    always @(posedge clk) begin
        if (!sram_csn) begin
            if (!sram_wen) mem[sram_addr] <= sram_din;
            else           sram_dout      <= mem[sram_addr];
        end
    end

    // Read-only macro model with latency 3 for the second instance.
    always @(posedge clk) begin
        if (!b_sram_csn && b_sram_wen) b_d0 <= mem[b_sram_addr];
        b_d1        <= b_d0;
        b_sram_dout <= b_d1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
        b_c0_req = 0; b_c0_we = 0; b_c0_addr = '0; b_c0_wdata = '0;
        b_c1_req = 0; b_c1_we = 0; b_c1_addr = '0; b_c1_wdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        vec++; if (sram_csn !== 1'b1) begin errs++; $display("FAIL reset_csn got %b exp 1", sram_csn); end
        vec++; if (sram_wen !== 1'b1) begin errs++; $display("FAIL reset_wen got %b exp 1", sram_wen); end
        vec++; if (sram_addr !== 13'd0) begin errs++; $display("FAIL reset_addr got %h exp 0", sram_addr); end
        vec++; if (sram_din !== 32'd0) begin errs++; $display("FAIL reset_din got %h exp 0", sram_din); end
        vec++; if (sram_nap !== 1'b0) begin errs++; $display("FAIL reset_nap got %b exp 0", sram_nap); end
        vec++; if (rdata !== 32'd0) begin errs++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        vec++; if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid} !== 4'b0000) begin errs++;
            $display("FAIL reset_gnt_rvalid got %b exp 0000", {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid}); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
        vec++; if ({sram_dvse, sram_dvs} !== 5'b0_0101) begin errs++;
            $display("FAIL reset_dvs got %b exp 00101", {sram_dvse, sram_dvs}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_write_then_read;
        do_reset();
        c0_req = 1; c0_we = 1; c0_addr = 13'd1; c0_wdata = 32'h1111_1111;
        #1;
        vec++; if (c0_gnt !== 1'b1) begin errs++; $display("FAIL wr_gnt got %b exp 1", c0_gnt); end
        tick();
        vec++; if ({sram_csn, sram_wen, sram_addr, sram_din} !== {1'b0, 1'b0, 13'd1, 32'h1111_1111}) begin errs++;
            $display("FAIL wr_cmd got csn=%b wen=%b a=%h d=%h exp 0 0 0001 11111111", sram_csn, sram_wen, sram_addr, sram_din); end
        c0_req = 0; c1_req = 1; c1_we = 0; c1_addr = 13'd1;
        #1;
        vec++; if ({c0_gnt, c1_gnt} !== 2'b01) begin errs++; $display("FAIL rd_gnt got %b exp 01", {c0_gnt, c1_gnt}); end
        tick();
        c1_req = 0;
        vec++; if ({sram_csn, sram_wen, sram_addr} !== {1'b0, 1'b1, 13'd1}) begin errs++;
            $display("FAIL rd_cmd got csn=%b wen=%b a=%h exp 0 1 0001", sram_csn, sram_wen, sram_addr); end
        tick();
        vec++; if ({c0_rvalid, c1_rvalid} !== 2'b00) begin errs++; $display("FAIL rv_early got %b exp 00", {c0_rvalid, c1_rvalid}); end
        tick();
        vec++; if ({c0_rvalid, c1_rvalid} !== 2'b01) begin errs++; $display("FAIL rv_pulse got %b exp 01", {c0_rvalid, c1_rvalid}); end
        vec++; if (rdata !== 32'h1111_1111) begin errs++; $display("FAIL rv_data got %h exp 11111111", rdata); end
        tick();
        vec++; if ({c0_rvalid, c1_rvalid} !== 2'b00) begin errs++; $display("FAIL rv_end got %b exp 00", {c0_rvalid, c1_rvalid}); end
        vec++; if (rdata !== 32'h1111_1111) begin errs++; $display("FAIL rv_hold got %h exp 11111111", rdata); end
    endtask

    task automatic test_back_to_back;
        int n0, n1, cl;
        logic [12:0] acc_addr [0:5];
        do_reset();
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                c0_req = 1; c0_we = 0; c0_addr = 13'(2 + n0);
                c1_req = 1; c1_we = 0; c1_addr = 13'(10 + n1);
                #1;
                vec++; if ({c0_gnt, c1_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errs++;
                    $display("FAIL b2b_gnt k=%0d got %b", k, {c0_gnt, c1_gnt}); end
                acc_addr[k] = (k % 2 == 0) ? 13'(2 + n0) : 13'(10 + n1);
                if (k % 2 == 0) n0++; else n1++;
            end else begin
                c0_req = 0; c1_req = 0;
            end
            tick();
            if (k < 6) begin
                vec++; if ({sram_csn, sram_addr} !== {1'b0, acc_addr[k]}) begin errs++;
                    $display("FAIL b2b_cmd k=%0d got csn=%b a=%h exp 0 %h", k, sram_csn, sram_addr, acc_addr[k]); end
            end
            if (k >= 2) begin
                cl = (k - 2) % 2;
                vec++; if ({c0_rvalid, c1_rvalid} !== ((cl == 0) ? 2'b10 : 2'b01)) begin errs++;
                    $display("FAIL b2b_rv k=%0d got %b", k, {c0_rvalid, c1_rvalid}); end
                vec++; if (rdata !== (32'hA500_0000 | 32'(acc_addr[k-2]))) begin errs++;
                    $display("FAIL b2b_data k=%0d got %h exp %h", k, rdata, 32'hA500_0000 | 32'(acc_addr[k-2])); end
            end
        end
        vec++; if (sram_csn !== 1'b1) begin errs++; $display("FAIL b2b_csn_idle got %b exp 1", sram_csn); end
    endtask

    task automatic test_write_read_same;
        int nwen;
        do_reset();
        nwen = 0;
        c0_req = 1; c0_we = 1; c0_addr = 13'd5; c0_wdata = 32'h1111_0000;
        tick();
        if (sram_wen === 1'b0) nwen++;
        c0_we = 0;
        #1;
        vec++; if (c0_gnt !== 1'b1) begin errs++; $display("FAIL wrs_gnt got %b exp 1", c0_gnt); end
        tick();
        if (sram_wen === 1'b0) nwen++;
        c0_req = 0;
        vec++; if ({sram_csn, sram_wen} !== 2'b01) begin errs++; $display("FAIL wrs_rdcmd got %b exp 01", {sram_csn, sram_wen}); end
        tick();
        if (sram_wen === 1'b0) nwen++;
        tick();
        if (sram_wen === 1'b0) nwen++;
        vec++; if ({c0_rvalid, rdata} !== {1'b1, 32'h1111_0000}) begin errs++;
            $display("FAIL wrs_data got rv=%b d=%h exp 1 11110000", c0_rvalid, rdata); end
        vec++; if (nwen !== 1) begin errs++; $display("FAIL wrs_wen_count got %0d exp 1", nwen); end
    endtask

    task automatic test_nap;
        do_reset();
        c0_req = 1; c0_we = 1; c0_addr = 13'd6; c0_wdata = 32'hCAFE_0006;
        tick();
        c0_req = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vec++; if (sram_nap !== 1'b0) begin errs++; $display("FAIL nap_early idle=%0d got %b exp 0", k, sram_nap); end
        end
        tick();
        vec++; if ({sram_nap, busy} !== 2'b11) begin errs++; $display("FAIL nap_enter got nap,busy=%b exp 11", {sram_nap, busy}); end
        c1_req = 1; c1_we = 0; c1_addr = 13'd6;
        #1;
        vec++; if (c1_gnt !== 1'b0) begin errs++; $display("FAIL nap_sleep_gnt got %b exp 0", c1_gnt); end
        tick();
        vec++; if ({sram_nap, c1_gnt} !== 2'b00) begin errs++; $display("FAIL nap_wake0 got nap,gnt=%b exp 00", {sram_nap, c1_gnt}); end
        tick();
        vec++; if (c1_gnt !== 1'b0) begin errs++; $display("FAIL nap_wake1 got %b exp 0", c1_gnt); end
        tick();
        vec++; if (c1_gnt !== 1'b1) begin errs++; $display("FAIL nap_active_gnt got %b exp 1", c1_gnt); end
        tick();
        c1_req = 0;
        tick();
        tick();
        vec++; if ({c1_rvalid, rdata} !== {1'b1, 32'hCAFE_0006}) begin errs++;
            $display("FAIL nap_rdata got rv=%b d=%h exp 1 cafe0006", c1_rvalid, rdata); end
    endtask

    task automatic test_nap_deferred;
        do_reset();
        b_c0_req = 1; b_c0_we = 0; b_c0_addr = 13'd7;
        #1;
        vec++; if (b_c0_gnt !== 1'b1) begin errs++; $display("FAIL def_gnt got %b exp 1", b_c0_gnt); end
        tick();
        b_c0_req = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            vec++; if (b_sram_nap !== (k == 5)) begin errs++; $display("FAIL def_nap k=%0d got %b", k, b_sram_nap); end
            vec++; if (b_c0_rvalid !== (k == 4)) begin errs++; $display("FAIL def_rv k=%0d got %b", k, b_c0_rvalid); end
            if (k == 4) begin
                vec++; if (b_rdata !== 32'hA500_0007) begin errs++; $display("FAIL def_data got %h exp a5000007", b_rdata); end
            end
        end
    endtask

    task automatic test_reset_midop;
        do_reset();
        c0_req = 1; c0_we = 0; c0_addr = 13'd2;
        tick();
        c0_addr = 13'd3;
        tick();
        c0_req = 0;
        vec++; if ({sram_csn, sram_addr} !== {1'b0, 13'd3}) begin errs++;
            $display("FAIL mid_pre got csn=%b a=%h exp 0 0003", sram_csn, sram_addr); end
        rst_n = 1'b0;
        #1;
        vec++; if ({sram_csn, sram_wen, sram_addr, sram_din} !== {1'b1, 1'b1, 13'd0, 32'd0}) begin errs++;
            $display("FAIL mid_async got csn=%b wen=%b a=%h d=%h", sram_csn, sram_wen, sram_addr, sram_din); end
        vec++; if ({busy, c0_rvalid, c1_rvalid, sram_nap} !== 4'b0000) begin errs++;
            $display("FAIL mid_flags got %b exp 0000", {busy, c0_rvalid, c1_rvalid, sram_nap}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vec++; if ({c0_rvalid, c1_rvalid} !== 2'b00) begin errs++;
                $display("FAIL mid_no_rv k=%0d got %b exp 00", k, {c0_rvalid, c1_rvalid}); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'hA500_0000 | 32'(i);
        sram_dout = '0; b_d0 = '0; b_d1 = '0; b_sram_dout = '0;
        test_reset();
        test_write_then_read();
        test_back_to_back();
        test_write_read_same();
        test_nap();
        test_nap_deferred();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
